// File: rtl/pu_pkg.sv
// Shared types and default widths for the PU input-side sequencer.
package pu_pkg;

    localparam int PU_DATA_WIDTH  = 8;
    localparam int PU_NUM_MAC4    = 16;
    localparam int PU_WADDR_WIDTH = 7;
    localparam int PU_RADDR_WIDTH = 6;
    localparam int PU_CNT_WIDTH   = 8;
    localparam int PU_PIPE_LAT    = 4;
    localparam int PU_TIW         = PU_NUM_MAC4 * 4 * PU_DATA_WIDTH;
    localparam int PU_CACHE_AW    = 5;
    localparam int PU_BIAS_AW     = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLR   = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } pu_state_e;

endpackage

// File: rtl/pu_wb_delay.sv
// Valid+address shift register that lines result-memory writes up with the PU pipeline.
module pu_wb_delay
    import pu_pkg::*;
#(
    parameter int DEPTH = PU_PIPE_LAT,
    parameter int AW    = PU_RADDR_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    output logic          out_valid,
    output logic [AW-1:0] out_addr,
    output logic          pending
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [AW-1:0]    addr_q [DEPTH];
    logic [AW-1:0]    addr_d [DEPTH];

    // Address is zeroed when not valid so the write-address port stays quiet between writes.
    always_comb begin
        valid_d[0] = in_valid;
        addr_d[0]  = in_valid ? in_addr : '0;
        for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            addr_d[i]  = addr_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= addr_d[i];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_addr  = addr_q[DEPTH-1];
    assign pending   = |valid_q;

endmodule

// File: rtl/pu_ctrl.sv
// Command-driven sequencer feeding activation beats, weight addresses and flags into the PU,
// and scheduling one result-memory write per finished output.
module pu_ctrl
    import pu_pkg::*;
#(
    parameter  int DATA_WIDTH  = PU_DATA_WIDTH,
    parameter  int NUM_MAC4    = PU_NUM_MAC4,
    parameter  int WADDR_WIDTH = PU_WADDR_WIDTH,
    parameter  int RADDR_WIDTH = PU_RADDR_WIDTH,
    parameter  int CNT_WIDTH   = PU_CNT_WIDTH,
    parameter  int PIPE_LAT    = PU_PIPE_LAT,
    localparam int TIW         = NUM_MAC4 * 4 * DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [CNT_WIDTH-1:0]   cmd_num_psum,
    input  logic [RADDR_WIDTH-1:0] cmd_num_out,
    input  logic [WADDR_WIDTH-1:0] cmd_w_base,
    input  logic [RADDR_WIDTH-1:0] cmd_r_base,
    input  logic [2:0]             cmd_bias_addr,
    input  logic                   cmd_add_bias,
    input  logic                   cmd_relu,
    input  logic                   act_valid,
    output logic                   act_ready,
    input  logic [TIW-1:0]         act_data,
    output logic [TIW-1:0]         pu_data,
    output logic [WADDR_WIDTH-1:0] pu_w_rd_addr,
    output logic [2:0]             pu_bias_addr,
    output logic                   pu_add_bias,
    output logic                   pu_relu,
    output logic                   pu_done,
    output logic                   pu_cache_clear,
    output logic [4:0]             pu_cache_rd_addr,
    output logic [4:0]             pu_cache_wr_addr,
    output logic                   pu_r_wr_en,
    output logic [RADDR_WIDTH-1:0] pu_r_wr_addr,
    output logic                   busy,
    output logic                   cmd_done
);

    pu_state_e state_q, state_d;

    logic [CNT_WIDTH-1:0]   num_psum_q, num_psum_d;
    logic [CNT_WIDTH-1:0]   psum_idx_q, psum_idx_d;
    logic [RADDR_WIDTH-1:0] num_out_q, num_out_d;
    logic [RADDR_WIDTH-1:0] out_idx_q, out_idx_d;
    logic [RADDR_WIDTH-1:0] r_base_q, r_base_d;
    logic [RADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
    logic [WADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
    logic [WADDR_WIDTH-1:0] w_rd_addr_q, w_rd_addr_d;
    logic [2:0]             bias_addr_q, bias_addr_d;
    logic                   add_bias_en_q, add_bias_en_d;
    logic                   relu_en_q, relu_en_d;
    logic                   zero_q, zero_d;
    logic [TIW-1:0]         pu_data_q, pu_data_d;
    logic                   pu_done_q, pu_done_d;
    logic                   pu_add_bias_q, pu_add_bias_d;
    logic                   pu_relu_q, pu_relu_d;

    logic                   beat;
    logic                   last_psum;
    logic                   last_out;
    logic                   dl_valid;
    logic                   dl_pending;
    logic [RADDR_WIDTH-1:0] dl_addr;
    logic                   pending;

    always_comb begin
        state_d       = state_q;
        num_psum_d    = num_psum_q;
        num_out_d     = num_out_q;
        r_base_d      = r_base_q;
        bias_addr_d   = bias_addr_q;
        add_bias_en_d = add_bias_en_q;
        relu_en_d     = relu_en_q;
        zero_d        = zero_q;
        psum_idx_d    = psum_idx_q;
        out_idx_d     = out_idx_q;
        w_ptr_d       = w_ptr_q;
        w_rd_addr_d   = w_rd_addr_q;
        pu_data_d     = '0;
        pu_done_d     = 1'b0;
        pu_add_bias_d = 1'b0;
        pu_relu_d     = 1'b0;
        wb_addr_d     = '0;

        beat      = (state_q == ST_RUN) && act_valid;
        last_psum = (psum_idx_q == num_psum_q - CNT_WIDTH'(1));
        last_out  = (out_idx_q == num_out_q - RADDR_WIDTH'(1));

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    num_psum_d    = cmd_num_psum;
                    num_out_d     = cmd_num_out;
                    r_base_d      = cmd_r_base;
                    bias_addr_d   = cmd_bias_addr;
                    add_bias_en_d = cmd_add_bias;
                    relu_en_d     = cmd_relu;
                    zero_d        = (cmd_num_psum == '0) || (cmd_num_out == '0);
                    w_ptr_d       = cmd_w_base;
                    psum_idx_d    = '0;
                    out_idx_d     = '0;
                    state_d       = ST_CLR;
                end
            end
            ST_CLR: begin
                state_d = zero_q ? ST_DRAIN : ST_RUN;
            end
            ST_RUN: begin
                if (beat) begin
                    pu_data_d   = act_data;
                    w_rd_addr_d = w_ptr_q;
                    w_ptr_d     = w_ptr_q + WADDR_WIDTH'(1);
                    if (last_psum) begin
                        pu_done_d     = 1'b1;
                        pu_add_bias_d = add_bias_en_q;
                        pu_relu_d     = relu_en_q;
                        wb_addr_d     = r_base_q + out_idx_q;
                        psum_idx_d    = '0;
                        out_idx_d     = out_idx_q + RADDR_WIDTH'(1);
                        if (last_out) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        psum_idx_d = psum_idx_q + CNT_WIDTH'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (!pending) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            num_psum_q    <= '0;
            num_out_q     <= '0;
            r_base_q      <= '0;
            bias_addr_q   <= '0;
            add_bias_en_q <= 1'b0;
            relu_en_q     <= 1'b0;
            zero_q        <= 1'b0;
            psum_idx_q    <= '0;
            out_idx_q     <= '0;
            w_ptr_q       <= '0;
            w_rd_addr_q   <= '0;
            pu_data_q     <= '0;
            pu_done_q     <= 1'b0;
            pu_add_bias_q <= 1'b0;
            pu_relu_q     <= 1'b0;
            wb_addr_q     <= '0;
        end else begin
            state_q       <= state_d;
            num_psum_q    <= num_psum_d;
            num_out_q     <= num_out_d;
            r_base_q      <= r_base_d;
            bias_addr_q   <= bias_addr_d;
            add_bias_en_q <= add_bias_en_d;
            relu_en_q     <= relu_en_d;
            zero_q        <= zero_d;
            psum_idx_q    <= psum_idx_d;
            out_idx_q     <= out_idx_d;
            w_ptr_q       <= w_ptr_d;
            w_rd_addr_q   <= w_rd_addr_d;
            pu_data_q     <= pu_data_d;
            pu_done_q     <= pu_done_d;
            pu_add_bias_q <= pu_add_bias_d;
            pu_relu_q     <= pu_relu_d;
            wb_addr_q     <= wb_addr_d;
        end
    end

    // The write is launched from the registered done so it lands PIPE_LAT cycles after pu_done.
    pu_wb_delay #(
        .DEPTH (PIPE_LAT),
        .AW    (RADDR_WIDTH)
    ) u_wb_delay (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (pu_done_q),
        .in_addr   (wb_addr_q),
        .out_valid (dl_valid),
        .out_addr  (dl_addr),
        .pending   (dl_pending)
    );

    assign pending = pu_done_q | dl_pending;

    assign cmd_ready        = (state_q == ST_IDLE) && !rst;
    assign act_ready        = (state_q == ST_RUN);
    assign busy             = (state_q != ST_IDLE);
    assign cmd_done         = (state_q == ST_DRAIN) && !pending;
    assign pu_cache_clear   = (state_q == ST_CLR);
    assign pu_data          = pu_data_q;
    assign pu_w_rd_addr     = w_rd_addr_q;
    assign pu_bias_addr     = bias_addr_q;
    assign pu_add_bias      = pu_add_bias_q;
    assign pu_relu          = pu_relu_q;
    assign pu_done          = pu_done_q;
    assign pu_cache_rd_addr = out_idx_q[4:0];
    assign pu_cache_wr_addr = out_idx_q[4:0];
    assign pu_r_wr_en       = dl_valid;
    assign pu_r_wr_addr     = dl_addr;

endmodule

// File: tb/tb_pu_ctrl.sv
// Scoreboard bench for pu_ctrl: expected beats and result writes are queued as stimulus is driven.
module tb_pu_ctrl;

    localparam int DW  = 8;
    localparam int NM  = 16;
    localparam int WAW = 7;
    localparam int RAW = 6;
    localparam int CW  = 8;
    localparam int PL  = 4;
    localparam int TIW = NM * 4 * DW;

    logic           clk = 1'b0;
    logic           rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [CW-1:0]  cmd_num_psum;
    logic [RAW-1:0] cmd_num_out;
    logic [WAW-1:0] cmd_w_base;
    logic [RAW-1:0] cmd_r_base;
    logic [2:0]     cmd_bias_addr;
    logic           cmd_add_bias;
    logic           cmd_relu;
    logic           act_valid;
    logic           act_ready;
    logic [TIW-1:0] act_data;
    logic [TIW-1:0] pu_data;
    logic [WAW-1:0] pu_w_rd_addr;
    logic [2:0]     pu_bias_addr;
    logic           pu_add_bias;
    logic           pu_relu;
    logic           pu_done;
    logic           pu_cache_clear;
    logic [4:0]     pu_cache_rd_addr;
    logic [4:0]     pu_cache_wr_addr;
    logic           pu_r_wr_en;
    logic [RAW-1:0] pu_r_wr_addr;
    logic           busy;
    logic           cmd_done;

    pu_ctrl #(
        .DATA_WIDTH  (DW),
        .NUM_MAC4    (NM),
        .WADDR_WIDTH (WAW),
        .RADDR_WIDTH (RAW),
        .CNT_WIDTH   (CW),
        .PIPE_LAT    (PL)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_num_psum     (cmd_num_psum),
        .cmd_num_out      (cmd_num_out),
        .cmd_w_base       (cmd_w_base),
        .cmd_r_base       (cmd_r_base),
        .cmd_bias_addr    (cmd_bias_addr),
        .cmd_add_bias     (cmd_add_bias),
        .cmd_relu         (cmd_relu),
        .act_valid        (act_valid),
        .act_ready        (act_ready),
        .act_data         (act_data),
        .pu_data          (pu_data),
        .pu_w_rd_addr     (pu_w_rd_addr),
        .pu_bias_addr     (pu_bias_addr),
        .pu_add_bias      (pu_add_bias),
        .pu_relu          (pu_relu),
        .pu_done          (pu_done),
        .pu_cache_clear   (pu_cache_clear),
        .pu_cache_rd_addr (pu_cache_rd_addr),
        .pu_cache_wr_addr (pu_cache_wr_addr),
        .pu_r_wr_en       (pu_r_wr_en),
        .pu_r_wr_addr     (pu_r_wr_addr),
        .busy             (busy),
        .cmd_done         (cmd_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int             due;
        logic [TIW-1:0] data;
        logic [WAW-1:0] waddr;
        logic           done;
        logic           bias;
        logic           relu;
    } beat_t;

    typedef struct {
        int             due;
        logic [RAW-1:0] addr;
    } wr_t;

    typedef enum logic [1:0] {M_IDLE, M_CLR, M_RUN, M_DRAIN} mstate_e;

    beat_t          beat_q[$];
    wr_t            wr_q[$];
    mstate_e        m_state = M_IDLE;
    logic [RAW-1:0] m_out_idx = '0;
    logic [WAW-1:0] exp_waddr = '0;
    logic [2:0]     exp_bias = '0;
    int             checks = 0;
    int             errors = 0;

    function automatic logic [TIW-1:0] rand_beat();
        logic [TIW-1:0] v;
        for (int i = 0; i < TIW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Drives one command to completion; pat 0=act_valid always, 1=toggling 1010, 2=random.
    task automatic run_cmd(input string name, input int np, input int no, input int wb, input int rb,
                           input logic [2:0] ba, input logic ab, input logic rl,
                           input int pat, input bit spam);
        int k, k0, done_cyc, psum, outi;
        bit accepted;
        logic [WAW-1:0] wptr;
        beat_t b;
        wr_t w;
        logic last;
        done_cyc = -1; psum = 0; outi = 0; accepted = 0; k0 = -1;
        wptr = WAW'(wb);
        forever begin
            @(negedge clk);
            k = cyc;
            if (k0 < 0) k0 = k;

            checks++;
            if (cmd_ready !== (m_state == M_IDLE) || act_ready !== (m_state == M_RUN) ||
                busy !== (m_state != M_IDLE) || pu_cache_clear !== (m_state == M_CLR) ||
                cmd_done !== (k == done_cyc)) begin
                errors++;
                $display("FAIL %s status cyc=%0d: ready/act_ready/busy/clear/done=%b%b%b%b%b required %b%b%b%b%b",
                         name, k - k0, cmd_ready, act_ready, busy, pu_cache_clear, cmd_done,
                         m_state == M_IDLE, m_state == M_RUN, m_state != M_IDLE, m_state == M_CLR, k == done_cyc);
            end

            checks++;
            if (pu_cache_rd_addr !== m_out_idx[4:0] || pu_cache_wr_addr !== m_out_idx[4:0] ||
                pu_bias_addr !== exp_bias) begin
                errors++;
                $display("FAIL %s cache/bias cyc=%0d: rd=%0d wr=%0d bias=%0d required %0d %0d %0d",
                         name, k - k0, pu_cache_rd_addr, pu_cache_wr_addr, pu_bias_addr,
                         m_out_idx[4:0], m_out_idx[4:0], exp_bias);
            end

            checks++;
            if (beat_q.size() > 0 && beat_q[0].due == k) begin
                b = beat_q.pop_front();
                exp_waddr = b.waddr;
            end else begin
                b.data = '0; b.waddr = exp_waddr; b.done = 0; b.bias = 0; b.relu = 0;
            end
            if (pu_data !== b.data || pu_w_rd_addr !== b.waddr || pu_done !== b.done ||
                pu_add_bias !== b.bias || pu_relu !== b.relu) begin
                errors++;
                $display("FAIL %s beat cyc=%0d: data[63:0]=%h waddr=%0d done=%b bias=%b relu=%b required %h %0d %b %b %b",
                         name, k - k0, pu_data[63:0], pu_w_rd_addr, pu_done, pu_add_bias, pu_relu,
                         b.data[63:0], b.waddr, b.done, b.bias, b.relu);
            end

            checks++;
            if (wr_q.size() > 0 && wr_q[0].due == k) begin
                w = wr_q.pop_front();
                if (pu_r_wr_en !== 1'b1 || pu_r_wr_addr !== w.addr) begin
                    errors++;
                    $display("FAIL %s rmem_write cyc=%0d: en=%b addr=%0d required 1 %0d",
                             name, k - k0, pu_r_wr_en, pu_r_wr_addr, w.addr);
                end
            end else if (pu_r_wr_en !== 1'b0) begin
                errors++;
                $display("FAIL %s rmem_idle cyc=%0d: en=%b required 0", name, k - k0, pu_r_wr_en);
            end

            if (done_cyc >= 0 && k == done_cyc + 1) break;
            if (k - k0 > 600) begin
                errors++;
                $display("FAIL %s timeout: cmd_done never came within 600 cycles", name);
                break;
            end

            if (m_state == M_IDLE && !accepted) begin
                cmd_valid = 1'b1;
                cmd_num_psum = CW'(np); cmd_num_out = RAW'(no);
                cmd_w_base = WAW'(wb); cmd_r_base = RAW'(rb);
                cmd_bias_addr = ba; cmd_add_bias = ab; cmd_relu = rl;
            end else if (spam && m_state != M_IDLE) begin
                cmd_valid = 1'b1;
                cmd_num_psum = CW'($urandom_range(1, 3)); cmd_num_out = RAW'($urandom_range(1, 3));
                cmd_w_base = WAW'($urandom); cmd_r_base = RAW'($urandom);
                cmd_bias_addr = ~ba; cmd_add_bias = ~ab; cmd_relu = ~rl;
            end else begin
                cmd_valid = 1'b0;
            end
            case (pat)
                0:       act_valid = 1'b1;
                1:       act_valid = ((k - k0) % 2 == 0);
                default: act_valid = 1'($urandom_range(0, 1));
            endcase
            act_data = rand_beat();

            case (m_state)
                M_IDLE: if (cmd_valid) begin
                    m_state = M_CLR; m_out_idx = '0; accepted = 1; exp_bias = ba;
                end
                M_CLR: begin
                    if (np == 0 || no == 0) begin
                        m_state = M_DRAIN; done_cyc = k + 1;
                    end else begin
                        m_state = M_RUN;
                    end
                end
                M_RUN: if (act_valid) begin
                    last = (psum == np - 1);
                    beat_q.push_back('{k + 1, act_data, wptr, last, last & ab, last & rl});
                    wptr = wptr + 1'b1;
                    if (last) begin
                        wr_q.push_back('{k + 1 + PL, RAW'(rb + outi)});
                        psum = 0; outi++;
                        m_out_idx = RAW'(outi);
                        if (outi == no) begin
                            m_state = M_DRAIN; done_cyc = k + 2 + PL;
                        end
                    end else begin
                        psum++;
                    end
                end
                M_DRAIN: if (k == done_cyc) m_state = M_IDLE;
                default: m_state = M_IDLE;
            endcase
        end
        cmd_valid = 1'b0;
        act_valid = 1'b0;
        checks++;
        if (beat_q.size() != 0 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL %s leftover: beats=%0d writes=%0d required 0 0", name, beat_q.size(), wr_q.size());
        end
        beat_q.delete();
        wr_q.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (pu_data !== '0 || {pu_w_rd_addr, pu_bias_addr, pu_cache_rd_addr, pu_cache_wr_addr, pu_r_wr_addr} !== '0) begin
            errors++;
            $display("FAIL reset_data_addr: data[63:0]=%h waddr=%0d r_wr_addr=%0d required 0", pu_data[63:0], pu_w_rd_addr, pu_r_wr_addr);
        end
        checks++;
        if ({pu_add_bias, pu_relu, pu_done, pu_cache_clear, pu_r_wr_en, busy, cmd_done, cmd_ready, act_ready} !== '0) begin
            errors++;
            $display("FAIL reset_flags: %b required 000000000",
                     {pu_add_bias, pu_relu, pu_done, pu_cache_clear, pu_r_wr_en, busy, cmd_done, cmd_ready, act_ready});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: cmd_ready=%b busy=%b required 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_basic();
        run_cmd("basic", 3, 2, 10, 5, 3'd1, 1'b1, 1'b1, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_cmd("back_to_back", 1, 4, 40, 20, 3'd6, 1'b1, 1'b0, 0, 1'b0);
    endtask

    task automatic test_bubbles();
        run_cmd("bubbles", 2, 3, 64, 30, 3'd2, 1'b0, 1'b1, 1, 1'b1);
    endtask

    task automatic test_wrap();
        run_cmd("wrap", 4, 2, 126, 63, 3'd7, 1'b1, 1'b1, 0, 1'b0);
    endtask

    task automatic test_zero();
        run_cmd("zero_out", 3, 0, 5, 9, 3'd4, 1'b1, 1'b1, 0, 1'b1);
        run_cmd("zero_psum", 0, 3, 5, 9, 3'd3, 1'b0, 1'b0, 0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 3; i++)
            run_cmd("random", $urandom_range(1, 4), $urandom_range(1, 5), $urandom_range(0, 127),
                    $urandom_range(0, 63), 3'($urandom), 1'($urandom), 1'($urandom), 2, 1'b1);
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_num_psum = 8'd2; cmd_num_out = 6'd3; cmd_w_base = 7'd20;
        cmd_r_base = 6'd8; cmd_bias_addr = 3'd5; cmd_add_bias = 1'b1; cmd_relu = 1'b1;
        act_valid = 1'b1; act_data = rand_beat();
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            act_data = rand_beat();
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (pu_data !== '0 || {pu_w_rd_addr, pu_bias_addr, pu_cache_rd_addr, pu_cache_wr_addr, pu_r_wr_addr} !== '0) begin
            errors++;
            $display("FAIL midrun_reset_data_addr: data[63:0]=%h waddr=%0d bias=%0d cache=%0d required 0",
                     pu_data[63:0], pu_w_rd_addr, pu_bias_addr, pu_cache_rd_addr);
        end
        checks++;
        if ({pu_add_bias, pu_relu, pu_done, pu_cache_clear, pu_r_wr_en, busy, cmd_done, cmd_ready, act_ready} !== '0) begin
            errors++;
            $display("FAIL midrun_reset_flags: %b required 000000000",
                     {pu_add_bias, pu_relu, pu_done, pu_cache_clear, pu_r_wr_en, busy, cmd_done, cmd_ready, act_ready});
        end
        act_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_state = M_IDLE; m_out_idx = '0; exp_waddr = '0; exp_bias = '0;
        repeat (12) begin
            @(negedge clk);
            checks++;
            if (pu_r_wr_en !== 1'b0 || cmd_done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midrun_aftermath: r_wr_en=%b cmd_done=%b cmd_ready=%b busy=%b required 0 0 1 0",
                         pu_r_wr_en, cmd_done, cmd_ready, busy);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_num_psum = '0; cmd_num_out = '0; cmd_w_base = '0; cmd_r_base = '0;
        cmd_bias_addr = '0; cmd_add_bias = 1'b0; cmd_relu = 1'b0;
        act_valid = 1'b0; act_data = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_bubbles();
        test_wrap();
        test_zero();
        test_random();
        test_reset_mid_run();
        test_basic();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
